mem_store_fwd_unit: RTL
=======================

Name: mem_store_fwd_unit

Overview:
Parametrised store-data forwarding unit for the MEM stage. It generalises the fixed two-source SW forwarding (arithmetic result from MEM/WB, or LW data from MEM/WB) into a priority bypass. Sources are the live writeback and a DEPTH-entry history of recently retired register writes. The history covers writebacks that already left the pipeline but may not yet be visible on the register-file read data captured earlier. The block sits between the EX/MEM register and data-memory write-data input, alongside the existing forwarding units.

Parameters:
DATA_W, 16, register/data width
REG_W, 3, register address width
DEPTH, 2, number of retired-write history entries (1..8)
SEL_W, 4, width of fwd_sel; must satisfy 2^SEL_W >= DEPTH+2
CNT_W, 16, width of forwarding hit counter

Ports:
clk  input  1  clock, all state updates on rising edge
reset_n  input  1  synchronous active-low reset
flush_i  input  1  pipeline flush; invalidates history
wb_we  input  1  MEM/WB stage commits a register write this cycle (already gated by CCR/condition for ADC/ADZ/NDC/NDZ and by LW)
wb_reg  input  REG_W  destination register of the MEM/WB write
wb_data  input  DATA_W  value written (ALU result or load data)
mem_is_store  input  1  EX/MEM instruction is SW
mem_src_reg  input  REG_W  SW data register (regA) in EX/MEM
mem_rf_data  input  DATA_W  regA value carried down the pipe from decode
mem_store_data  output  DATA_W  forwarded store data to data memory
fwd_sel  output  SEL_W  source chosen: 0 = pipe value, 1 = live WB, 2+k = history entry k (k=0 newest)
fwd_hit  output  1  high when mem_is_store and fwd_sel != 0
hit_count  output  CNT_W  saturating count of cycles with fwd_hit high

Behaviour:
- History: DEPTH entries {valid, reg, data}; entry 0 is newest.
- On a clock edge with wb_we=1 and no flush, the history shifts: entry k takes entry k-1, entry 0 takes {1, wb_reg, wb_data}, and the oldest entry is dropped.
- With wb_we=0, the history holds.
- No dedup: the same register may occupy several entries; the newest entry always wins selection.
- Selection is combinational, same cycle, zero latency. Priority:
  1) wb_we && wb_reg==mem_src_reg → wb_data, fwd_sel=1.
  2) Lowest k with valid[k] && reg[k]==mem_src_reg → data[k], fwd_sel=2+k.
  3) Otherwise mem_rf_data, fwd_sel=0.
- mem_is_store=0: mem_store_data = mem_rf_data, fwd_sel=0, fwd_hit=0. The history still updates.
- hit_count increments by 1 on each edge where fwd_hit=1. It saturates at all-ones and never wraps.
- flush_i=1 on an edge: all valid bits cleared. A wb_we in the same cycle is NOT captured, because the flushed writeback is architecturally squashed upstream. hit_count is unaffected by flush.
- Reset (reset_n=0 on an edge): all valid bits 0, reg/data 0, hit_count 0. Reset takes priority over flush and wb_we.
- Reset asserted mid-operation: next-cycle outputs reflect an empty history, i.e. fwd_sel is 0 unless the live-WB match applies. Combinational outputs during reset still follow priority rules 1 and 3.
- No stall input. The EX/MEM SW is re-evaluated every cycle. A stalled SW therefore sees the history advance, which is correct because newer writes are younger state.

Test Plan:
- Reset, then SW r3 with mem_rf_data=0x1111, no writes → mem_store_data=0x1111, fwd_sel=0, fwd_hit=0, hit_count=0.
- Same cycle wb_we=1, wb_reg=3, wb_data=0xABCD, SW r3 → 0xABCD, fwd_sel=1, fwd_hit=1; hit_count=1 after the edge.
- Write r5=0x0055, then write r2=0x0022, then SW r5 with wb_we=0 → data 0x0055, fwd_sel=3 (entry 1). Then write r6 with DEPTH=2 → r5 evicted, SW r5 returns mem_rf_data, fwd_sel=0.
- Write r4=0x0001, then write r4=0x0002, then SW r4 → 0x0002 from entry 0 (fwd_sel=2), not 0x0001.
- Two writes, then flush_i with wb_we=1 (r4=0x0099) on the same edge, then SW r4 → mem_rf_data, fwd_sel=0, history all invalid.
- With CNT_W=2, hold a forwarding SW for 5 cycles → hit_count sequence 1,2,3,3,3. Then assert reset_n=0 for one edge → hit_count=0 and history empty.

Source files
------------

// File: rtl/mem_store_fwd_unit.sv
// Store-data forwarding for the MEM stage: selects SW write data from the live
// writeback, a short history of retired register writes, or the piped regA value.
module mem_store_fwd_unit #(
  parameter int DATA_W = 16,
  parameter int REG_W  = 3,
  parameter int DEPTH  = 2,
  parameter int SEL_W  = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush_i,
  input  logic              wb_we,
  input  logic [REG_W-1:0]  wb_reg,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              mem_is_store,
  input  logic [REG_W-1:0]  mem_src_reg,
  input  logic [DATA_W-1:0] mem_rf_data,
  output logic [DATA_W-1:0] mem_store_data,
  output logic [SEL_W-1:0]  fwd_sel,
  output logic              fwd_hit,
  output logic [CNT_W-1:0]  hit_count
);

  logic [DEPTH-1:0]  hist_vld_q, hist_vld_d;
  logic [REG_W-1:0]  hist_reg_q  [DEPTH];
  logic [REG_W-1:0]  hist_reg_d  [DEPTH];
  logic [DATA_W-1:0] hist_data_q [DEPTH];
  logic [DATA_W-1:0] hist_data_d [DEPTH];
  logic [CNT_W-1:0]  hit_cnt_q, hit_cnt_d;

  logic [SEL_W-1:0]  sel;
  logic [DATA_W-1:0] sel_data;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) return v;
    return v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  // Priority select; the history is masked while reset is asserted. Scanning
  // from the oldest entry lets the newest matching entry overwrite the result.
  always_comb begin
    sel      = '0;
    sel_data = mem_rf_data;
    if (mem_is_store) begin
      if (wb_we && (wb_reg == mem_src_reg)) begin
        sel      = SEL_W'(1);
        sel_data = wb_data;
      end else if (reset_n) begin
        for (int k = DEPTH - 1; k >= 0; k--) begin
          if (hist_vld_q[k] && (hist_reg_q[k] == mem_src_reg)) begin
            sel      = SEL_W'(k + 2);
            sel_data = hist_data_q[k];
          end
        end
      end
    end
  end

  assign mem_store_data = sel_data;
  assign fwd_sel        = sel;
  assign fwd_hit        = (sel != '0);
  assign hit_count      = hit_cnt_q;

  // A flushed writeback is squashed upstream, so flush wins over capture.
  always_comb begin
    hist_vld_d  = hist_vld_q;
    hist_reg_d  = hist_reg_q;
    hist_data_d = hist_data_q;
    hit_cnt_d   = fwd_hit ? sat_inc(hit_cnt_q) : hit_cnt_q;
    if (flush_i) begin
      hist_vld_d = '0;
    end else if (wb_we) begin
      for (int k = DEPTH - 1; k >= 1; k--) begin
        hist_vld_d[k]  = hist_vld_q[k-1];
        hist_reg_d[k]  = hist_reg_q[k-1];
        hist_data_d[k] = hist_data_q[k-1];
      end
      hist_vld_d[0]  = 1'b1;
      hist_reg_d[0]  = wb_reg;
      hist_data_d[0] = wb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hist_vld_q <= '0;
      hit_cnt_q  <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        hist_reg_q[k]  <= '0;
        hist_data_q[k] <= '0;
      end
    end else begin
      hist_vld_q  <= hist_vld_d;
      hist_reg_q  <= hist_reg_d;
      hist_data_q <= hist_data_d;
      hit_cnt_q   <= hit_cnt_d;
    end
  end

endmodule
